sync_multi: RTL and testbench



---
 rtl/sync_multi_pkg.sv | 23 ++
 rtl/sync_bit.sv | 26 ++
 rtl/sync_multi.sv | 111 +++++++++++
 tb/tb_sync_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sync_multi_pkg.sv
// rtl/sync_multi_pkg.sv - shared types and synchronizer depth for sync_multi
// Holds the TX/RX handshake state enums and SYNC_STAGES.
// Macro SYNC_MULTI_SYNC3_EN: when defined, both handshake synchronizers are 3 stages deep, else 2.
package sync_multi_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_DROP = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

`ifdef SYNC_MULTI_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit flop-chain synchronizer
// Ports: clk (rising edge), reset (async active-low, clears chain to 0),
//        din (bit to synchronize), dout (din delayed by STAGES flops).
// Parameter STAGES: chain depth, at least 2.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/sync_multi.sv
// rtl/sync_multi.sv - multi-bit data synchronizer over a four-phase req/ack handshake
// Ports: clk (rising edge), reset (async active-low), in_data/v (producer word and valid level),
//        out_data (delivered word, held until next delivery), f (busy, v ignored),
//        d (one-cycle strobe marking a new out_data).
// Parameter DATA_WIDTH: word width. Macro SYNC_MULTI_SYNC3_EN selects 3-stage synchronizers.
module sync_multi
    import sync_multi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  v,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  f,
    output logic                  d
);

    tx_state_t             tx_state;
    rx_state_t             rx_state;
    logic                  req;
    logic                  ack;
    logic                  req_s;
    logic                  ack_s;
    // Crosses to the RX side unsynchronized; the handshake keeps it stable
    // from capture until ack_s has dropped again.
    logic [DATA_WIDTH-1:0] tx_data;

    sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .din   (req),
        .dout  (req_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ack),
        .dout  (ack_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            req      <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (v) begin
                        tx_data  <= in_data;
                        req      <= 1'b1;
                        tx_state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (ack_s) begin
                        req      <= 1'b0;
                        tx_state <= TX_DROP;
                    end
                end
                TX_DROP: begin
                    // Wait for the receiver to lower ack before accepting again.
                    if (!ack_s) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    req      <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign f = (tx_state != TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            ack      <= 1'b0;
            out_data <= '0;
            d        <= 1'b0;
        end else begin
            d <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (req_s) begin
                        out_data <= tx_data;
                        d        <= 1'b1;
                        ack      <= 1'b1;
                        rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!req_s) begin
                        ack      <= 1'b0;
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    ack      <= 1'b0;
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_multi.sv
// tb/tb_sync_multi.sv - scoreboard testbench for sync_multi
module tb_sync_multi;

`ifdef SYNC_MULTI_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       v = 1'b0;
    logic [7:0] out_data;
    logic       f;
    logic       d;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   e0;
    exp_t sb[$];

    sync_multi #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .v        (v),
        .out_data (out_data),
        .f        (f),
        .d        (d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] data, input int at);
        exp_t e;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((f !== 1'b0 || sb.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check("idle_reached", {31'b0, (f !== 1'b0) || (sb.size() != 0)}, 32'd0);
        step();
        step();
    endtask

    always @(negedge clk) begin
        if (d === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_d", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {24'b0, out_data}, {24'b0, e.data});
                check("d_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        // Reset with active producer: nothing may transfer.
        in_data = 8'hFF;
        v = 1'b1;
        #1;
        check("rst_out_data", {24'b0, out_data}, 32'h00);
        check("rst_d", {31'b0, d}, 32'd0);
        check("rst_f", {31'b0, f}, 32'd0);
        repeat (5) step();
        check("rst_hold_f", {31'b0, f}, 32'd0);
        check("rst_hold_out", {24'b0, out_data}, 32'h00);
        v = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        check("post_rst_f", {31'b0, f}, 32'd0);

        // Single transfer with exact busy window.
        in_data = 8'hA5;
        v = 1'b1;
        e0 = cyc + 1;
        push(8'hA5, e0 + N + 1);
        step();
        v = 1'b0;
        in_data = 8'h00;
        check("single_f_e0", {31'b0, f}, 32'd1);
        for (int k = 1; k <= 4 * N + 4; k++) begin
            step();
            check("single_f", {31'b0, f}, {31'b0, (k < 4 * N + 4)});
        end
        wait_idle();

        // Held valid for three cycles yields one transfer.
        in_data = 8'h3C;
        v = 1'b1;
        e0 = cyc + 1;
        push(8'h3C, e0 + N + 1);
        repeat (3) step();
        v = 1'b0;
        wait_idle();
        check("held_out", {24'b0, out_data}, 32'h3C);

        // Request while busy is dropped.
        in_data = 8'h11;
        v = 1'b1;
        e0 = cyc + 1;
        push(8'h11, e0 + N + 1);
        step();
        v = 1'b0;
        repeat (4) step();
        in_data = 8'h22;
        v = 1'b1;
        step();
        check("busy_f", {31'b0, f}, 32'd1);
        v = 1'b0;
        in_data = 8'h77;
        wait_idle();
        check("busy_out", {24'b0, out_data}, 32'h11);

        // Back-to-back with valid held high.
        in_data = 8'h01;
        v = 1'b1;
        e0 = cyc + 1;
        push(8'h01, e0 + N + 1);
        push(8'h02, e0 + 4 * N + 5 + N + 1);
        step();
        for (int k = 1; k <= 4 * N + 5; k++) begin
            step();
            if (k == 6) in_data = 8'h02;
            if (k == 4 * N + 4) check("b2b_f_gap", {31'b0, f}, 32'd0);
            if (k == 4 * N + 5) check("b2b_f_again", {31'b0, f}, 32'd1);
        end
        v = 1'b0;
        wait_idle();
        check("b2b_out", {24'b0, out_data}, 32'h02);

        // Reset in the middle of a transfer: no strobe, then a clean retry.
        in_data = 8'h5A;
        v = 1'b1;
        step();
        v = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("midrst_f", {31'b0, f}, 32'd0);
        check("midrst_d", {31'b0, d}, 32'd0);
        check("midrst_out", {24'b0, out_data}, 32'h00);
        repeat (3) step();
        reset = 1'b1;
        repeat (2 * N + 4) step();
        check("midrst_quiet_f", {31'b0, f}, 32'd0);
        in_data = 8'h5A;
        v = 1'b1;
        e0 = cyc + 1;
        push(8'h5A, e0 + N + 1);
        step();
        v = 1'b0;
        wait_idle();
        check("midrst_retry_out", {24'b0, out_data}, 32'h5A);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
